// File: rtl/evaluate_recip_arbiter_pkg.sv
// Shared types and defaults for the round-robin reciprocal arbiter.
package evaluate_recip_pkg;

    localparam int TAU_W_DEF       = 39;
    localparam int NUMER_SHIFT_DEF = 39;
    localparam int Q_W_DEF         = 32;

    // Quotient bits returned for a zero divisor are all set to this value.
    localparam logic DIV0_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/evaluate_recip_arbiter_div.sv
// Iterative restoring divider: 2^NUMER_SHIFT / divisor, one quotient bit per cycle, MSB first.
module recip_div_seq
    import evaluate_recip_pkg::*;
#(
    parameter int TAU_W       = TAU_W_DEF,
    parameter int NUMER_SHIFT = NUMER_SHIFT_DEF,
    parameter int Q_W         = Q_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [TAU_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot,
    output logic             o_div0
);

    localparam int CNT_W = $clog2(NUMER_SHIFT + 1);

    logic [TAU_W-1:0] r_div;
    logic [TAU_W:0]   r_rem;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic             w_zero;
    logic             w_last;
    logic [TAU_W:0]   w_shift;
    logic             w_ge;
    logic [TAU_W:0]   w_rem_nxt;
    logic [Q_W-1:0]   w_q_nxt;

    // Numerator bit stream is a single 1 followed by zeros, so it is never stored.
    always_comb begin
        w_zero    = i_start && (i_divisor == '0);
        w_last    = r_run && (r_cnt == CNT_W'(NUMER_SHIFT));
        w_shift   = {r_rem[TAU_W-1:0], (r_cnt == '0)};
        w_ge      = (w_shift >= {1'b0, r_div});
        w_rem_nxt = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
        w_q_nxt   = {r_q[Q_W-2:0], w_ge};
    end

    // Done fires in the cycle whose edge completes the quotient; the caller latches o_quot then.
    assign o_done = w_last || w_zero;
    assign o_quot = w_zero ? {Q_W{DIV0_FILL}} : w_q_nxt;
    assign o_div0 = w_zero;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start && !w_zero) begin
            r_div <= i_divisor;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/evaluate_recip_arbiter.sv
// Round-robin arbiter sharing one sequential reciprocal unit among NUM_REQ tau requesters.
module evaluate_recip_arbiter
    import evaluate_recip_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TAU_W       = TAU_W_DEF,
    parameter int NUMER_SHIFT = NUMER_SHIFT_DEF,
    parameter int Q_W         = Q_W_DEF,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*TAU_W-1:0] i_req_tau,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    output logic [Q_W-1:0]           o_rsp_recip,
    output logic                     o_rsp_div0,
    output logic                     o_busy,
    output logic [ID_W-1:0]          o_grant_id
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [Q_W-1:0]    r_rsp_recip;
    logic              r_rsp_div0;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt;
    int                w_idx;
    logic              w_start;
    logic [TAU_W-1:0]  w_tau;
    logic              w_div_done;
    logic [Q_W-1:0]    w_quot;
    logic              w_div0;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;

    // Search starts just after the last grant, so the served requester ends up last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(w_idx);
            end
        end
    end

    assign w_start = (r_state == S_IDLE) && w_found;
    assign w_tau   = i_req_tau[int'(w_gnt)*TAU_W +: TAU_W];

    recip_div_seq #(
        .TAU_W       (TAU_W),
        .NUMER_SHIFT (NUMER_SHIFT),
        .Q_W         (Q_W)
    ) u_div (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (w_start),
        .i_divisor (w_tau),
        .o_done    (w_div_done),
        .o_quot    (w_quot),
        .o_div0    (w_div0)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_req_ready[w_gnt] = 1'b1;
                    w_state_nxt        = w_div0 ? S_DONE : S_DIV;
                end
            end
            S_DIV:  if (w_div_done) w_state_nxt = S_DONE;
            S_DONE: begin
                w_rsp_valid[r_grant_id] = 1'b1;
                w_state_nxt             = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_rsp_recip <= '0;
            r_rsp_div0  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_rr_ptr   <= w_gnt;
                r_grant_id <= w_gnt;
            end
            // Result registers load on the edge entering DONE, from either path.
            if ((w_start && w_div0) || (r_state == S_DIV && w_div_done)) begin
                r_rsp_recip <= w_quot;
                r_rsp_div0  <= w_div0;
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_recip = r_rsp_recip;
    assign o_rsp_div0  = r_rsp_div0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_grant_id  = r_grant_id;

endmodule

// File: doc/evaluate_recip_arbiter.md
Name: evaluate_recip_arbiter

Overview:
- Shares one iterative reciprocal unit (computes 2^NUMER_SHIFT / tau) among NUM_REQ fixed-point evaluate blocks.
- Replaces the per-block combinational divide used to turn a time constant tau into a rate.
- Requesters post tau values. The block grants them round-robin, runs a 1-bit/cycle restoring division, and returns the truncated quotient tagged to the granted requester.
- Sits between the evaluate_* integrators and the model step controller, on the model clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TAU_W, 39, width of unsigned tau operand
- NUMER_SHIFT, 39, numerator is 2^NUMER_SHIFT
- Q_W, 32, width of returned quotient (low Q_W bits of the full quotient)
- ID_W, 2, width of grant index, equal to clog2(NUM_REQ)

Ports:
- clk  input  1  model clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request
- req_tau  input  NUM_REQ*TAU_W  flattened tau operands; requester i at [i*TAU_W +: TAU_W]
- req_ready  output  NUM_REQ  one-hot accept strobe
- rsp_valid  output  NUM_REQ  one-hot, 1-cycle result strobe
- rsp_recip  output  Q_W  quotient for the requester strobed on rsp_valid
- rsp_div0  output  1  set with rsp_valid when tau was 0
- busy  output  1  high whenever the FSM is not in IDLE
- grant_id  output  ID_W  index of the current or last granted requester

Behaviour:
- Reset values:
  - FSM enters IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0, rsp_valid=0, rsp_recip=0, rsp_div0=0, busy=0, grant_id=0.
- Reset mid-operation aborts the in-flight division; no rsp_valid is produced for it.
- FSM states and transitions:
  - IDLE: if any req_valid, select g = first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap mod NUM_REQ.
    - req_ready[g]=1 combinationally in that cycle. This is the accept cycle, call it cycle 0.
    - On the edge: latch tau_q = req_tau[g], grant_id = g, rr_ptr = g.
    - If tau_q would be 0, go to DONE with div0 set; otherwise go to DIV.
    - With no req_valid, stay in IDLE.
  - DIV: restoring division of 2^NUMER_SHIFT by tau_q, one quotient bit per cycle, MSB first, NUMER_SHIFT+1 cycles.
    - Default timing: cycles 1..40, then DONE.
  - DONE: rsp_valid[grant_id]=1 for exactly one cycle; rsp_recip and rsp_div0 update in this cycle. Next state is IDLE.
- Latency:
  - Response in cycle NUMER_SHIFT+2 after accept (cycle 41 by default).
  - For tau=0, response in cycle 1.
  - Next accept no earlier than the cycle after DONE.
- Arithmetic:
  - Full quotient is NUMER_SHIFT+1 bits; rsp_recip = low Q_W bits (plain truncation, no saturation).
  - tau=0 gives rsp_recip = all ones and rsp_div0=1.
  - Remainder register is TAU_W+1 bits; the numerator is never materialised, only its bit stream (1 then zeros).
- Holding of outputs:
  - rsp_recip, rsp_div0 and grant_id hold until the next DONE or IDLE grant.
  - rsp_recip is meaningful only while rsp_valid.
- Handshake rules:
  - A requester holds req_valid and req_tau stable until it sees req_ready.
  - Deasserting req_valid before req_ready withdraws the request legally.
  - req_tau changes after accept do not affect the result.
  - req_ready is never asserted outside IDLE; at most one bit is ever set.
- Simultaneous events:
  - A new req_valid arriving during DIV or DONE waits; arbitration happens only in IDLE.
  - The requester just served is lowest priority in the next arbitration.

Decomposition:
- Package evaluate_recip_pkg:
  - FSM state encoding (IDLE, DIV, DONE).
  - Default widths: TAU_W, NUMER_SHIFT, Q_W.
  - Div-by-zero result constant.
- Sub-module recip_div_seq: iterative restoring divider.
  - Inputs: start, divisor.
  - Outputs: done pulse, quotient, div0.
  - Arbiter instantiates it once and owns arbitration, grant latching and the response strobe.

Test Plan:
- Reset then req_valid=0001, tau0=3 -> req_ready=0001 in cycle 0; rsp_valid=0001 in cycle 41; rsp_recip=0xAAAAAAAA; rsp_div0=0.
- Single requester, tau=2^20 -> rsp_recip=524288 (0x00080000). Same stimulus with tau=2^39-1 -> rsp_recip=1.
- tau=1 -> rsp_recip=0x00000000 (2^39 truncated), rsp_div0=0. tau=0 -> rsp_valid in cycle 1, rsp_recip=0xFFFFFFFF, rsp_div0=1.
- All four req_valid held from reset with distinct tau -> accepts at cycles 0, 42, 84, 126 to requesters 0, 1, 2, 3, then 0 again. Each rsp_valid bit matches its requester and each quotient matches its own tau.
- Assert reset at cycle 20 of a DIV -> no rsp_valid; busy=0 next cycle. A pending req_valid=0100 is then accepted by requester 2, with requester 0 back at first priority after reset.
- Requester 1 drops req_valid during another requester's DIV and requester 3 raises it -> next grant goes to 3. req_tau changed after accept does not alter rsp_recip.
